// File: rtl/cu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cu_sequencer
//  Description : Program sequencer and instruction decoder for the 4-bit
//                computational unit. Owns the program counter, registers each
//                fetched instruction byte and decodes it into the unit's
//                control inputs. Handles two-byte JMP / JNZ / JZ.
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic [7:0]      pm_data,
    input  logic            r_eq_0,
    output logic [PC_W-1:0] pm_address,
    output logic [7:0]      ir,
    output logic [3:0]      ir_nibble,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    localparam logic [3:0] c_SRC_PM_NIB = 4'd8;
    localparam logic [3:0] c_SRC_I_PINS = 4'd9;
    localparam logic [3:0] c_SRC_NONE   = 4'd10;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic            w_is_jump;
    logic            w_taken;
    logic [2:0]      w_dst;
    logic [2:0]      w_src;
    logic            w_autoinc;
    logic [3:0]      w_source_sel;
    logic [8:0]      w_reg_en;
    logic            w_i_sel;

    // Destination code to register-enable bit; code 4 addresses o_reg (bit 8)
    function automatic logic [8:0] f_dst_onehot(input logic [2:0] code);
        logic [8:0] v;
        v = 9'd0;
        if (code == 3'd4) begin
            v[8] = 1'b1;
        end else begin
            v[code] = 1'b1;
        end
        return v;
    endfunction

    // Jump target is the byte following the opcode, fitted to the pc width
    generate
        if (PC_W > 8) begin : g_target_wide
            assign w_target = {{(PC_W-8){1'b0}}, pm_data};
        end else begin : g_target_narrow
            assign w_target = pm_data[PC_W-1:0];
        end
    endgenerate

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_is_jump = (r_ir[7:5] == 3'b111);
    // 1110 = JMP, 1111_0 = JNZ, 1111_1 = JZ
    assign w_taken   = ~r_ir[4] | (r_ir[3] ? r_eq_0 : ~r_eq_0);
    assign w_dst     = r_ir[7] ? r_ir[5:3] : r_ir[6:4];
    assign w_src     = r_ir[2:0];

    // Fetch / pc sequencing; a jump always drops into a one-cycle bubble
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_pc    <= '0;
            r_ir    <= 8'h00;
            r_state <= ST_BUBBLE;
        end else begin
            r_ir <= pm_data;
            if (r_state == ST_RUN && w_is_jump) begin
                r_pc    <= w_taken ? w_target : w_pc_inc;
                r_state <= ST_BUBBLE;
            end else begin
                r_pc    <= w_pc_inc;
                r_state <= ST_RUN;
            end
        end
    end

    // Instruction decode; reset and bubble cycles issue no register writes
    always_comb begin
        w_source_sel = c_SRC_NONE;
        w_reg_en     = 9'd0;
        w_i_sel      = 1'b0;
        w_autoinc    = 1'b0;
        if (!sync_reset && r_state == ST_RUN) begin
            if (!r_ir[7]) begin
                // LOAD immediate nibble
                w_source_sel = c_SRC_PM_NIB;
                w_reg_en     = f_dst_onehot(w_dst);
                w_autoinc    = (w_dst == 3'd7);
            end else if (r_ir[6] == 1'b0) begin
                // MOVE; src == dst selects the input pins instead
                w_source_sel = (w_dst == w_src) ? c_SRC_I_PINS : {1'b0, w_src};
                w_reg_en     = f_dst_onehot(w_dst);
                w_autoinc    = (w_dst == 3'd7) ||
                               ((w_src == 3'd7) && (w_src != w_dst));
            end else if (r_ir[5] == 1'b0) begin
                // ALU: only the result register is written
                w_reg_en = 9'b0_0001_0000;
            end
            // Data-memory access post-increments i unless i itself is the target
            if (w_autoinc && w_dst != 3'd6) begin
                w_reg_en[6] = 1'b1;
                w_i_sel     = 1'b1;
            end
        end
    end

    assign pm_address = r_pc;
    assign ir         = r_ir;
    assign ir_nibble  = r_ir[3:0];
    assign x_sel      = r_ir[4];
    assign y_sel      = r_ir[3];
    assign source_sel = w_source_sel;
    assign reg_en     = w_reg_en;
    assign i_sel      = w_i_sel;

endmodule
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cu_sequencer
//  Description : Self-checking bench for cu_sequencer: decode vector table,
//                directed jump/reset sequences and a random program run
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       r_eq_0;
    logic [7:0] pm_data;
    logic [7:0] pm_address;
    logic [7:0] ir;
    logic [3:0] ir_nibble;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;

    logic [7:0] pm [256];
    int errors = 0;
    int checks = 0;
    int dmap [8] = '{0, 1, 2, 3, 8, 5, 6, 7};

    // reference model state
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    bit         m_bub;
    logic [3:0] ess;
    logic [8:0] ere;
    bit         eis;
    bit         taken;
    logic [7:0] nxt;

    cu_sequencer #(.PC_W(8)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_address (pm_address),
        .ir         (ir),
        .ir_nibble  (ir_nibble),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel)
    );

    assign pm_data = pm[pm_address];

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ins;
        logic [3:0] ss;
        logic [8:0] re;
        logic       is;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pm;
        for (int i = 0; i < 256; i++) pm[i] = 8'h00;
    endtask

    task automatic do_reset;
        sync_reset = 1'b1;
        cyc;
        cyc;
        sync_reset = 1'b0;
    endtask

    // Expected control outputs from the instruction-set rules
    function automatic void ref_dec(input logic [7:0] ins, input bit bub, input bit rst,
                                    output logic [3:0] ss, output logic [8:0] re,
                                    output bit is);
        int d;
        int s;
        bit incr;
        ss = 4'd10;
        re = 9'd0;
        is = 1'b0;
        d = 0;
        s = 0;
        incr = 1'b0;
        if (rst || bub) return;
        if (ins < 8'h80) begin
            d = int'(ins[6:4]);
            ss = 4'd8;
            re = 9'(1) << dmap[d];
            incr = (d == 7);
        end else if (ins < 8'hC0) begin
            d = int'(ins[5:3]);
            s = int'(ins[2:0]);
            ss = (d == s) ? 4'd9 : 4'(s);
            re = 9'(1) << dmap[d];
            incr = (d == 7) || (s == 7 && s != d);
        end else if (ins < 8'hE0) begin
            re = 9'h010;
        end
        if (incr && d != 6) begin
            re = re | 9'h040;
            is = 1'b1;
        end
    endfunction

    initial begin
        sync_reset = 1'b1;
        r_eq_0     = 1'b0;
        clear_pm();

        vt[0]  = '{8'h05, 4'd8,  9'h001, 1'b0};
        vt[1]  = '{8'h88, 4'd0,  9'h002, 1'b0};
        vt[2]  = '{8'hD2, 4'd10, 9'h010, 1'b0};
        vt[3]  = '{8'hA4, 4'd9,  9'h100, 1'b0};
        vt[4]  = '{8'hB8, 4'd0,  9'h0C0, 1'b1};
        vt[5]  = '{8'hB7, 4'd7,  9'h040, 1'b0};
        vt[6]  = '{8'h7F, 4'd8,  9'h0C0, 1'b1};
        vt[7]  = '{8'h6A, 4'd8,  9'h040, 1'b0};
        vt[8]  = '{8'h4F, 4'd8,  9'h100, 1'b0};
        vt[9]  = '{8'hBE, 4'd6,  9'h0C0, 1'b1};
        vt[10] = '{8'h87, 4'd7,  9'h041, 1'b1};
        vt[11] = '{8'h95, 4'd5,  9'h004, 1'b0};
        vt[12] = '{8'hE5, 4'd10, 9'h000, 1'b0};
        vt[13] = '{8'hF3, 4'd10, 9'h000, 1'b0};

        // ---- reset and straight-line program ----
        pm[0] = 8'h05; pm[1] = 8'h88; pm[2] = 8'hD2;
        pm[3] = 8'hA4; pm[4] = 8'hB8; pm[5] = 8'hB7;
        do_reset();
        chk("rst_reg_en", reg_en, 0);
        chk("rst_src", source_sel, 10);
        chk("rst_pc0", pm_address, 0);
        cyc;
        chk("boot_pc1", pm_address, 1);
        chk("boot_ir", ir, 8'h05);
        chk("load_src", source_sel, 8);
        chk("load_en", reg_en, 9'h001);
        chk("load_nib", ir_nibble, 5);
        cyc;
        chk("move_src", source_sel, 0);
        chk("move_en", reg_en, 9'h002);
        cyc;
        chk("alu_en", reg_en, 9'h010);
        chk("alu_x", x_sel, 1);
        chk("alu_y", y_sel, 0);
        chk("alu_nib", ir_nibble, 2);
        cyc;
        chk("mv_ipins_src", source_sel, 9);
        chk("mv_ipins_en", reg_en, 9'h100);
        cyc;
        chk("mv_dm_src", source_sel, 0);
        chk("mv_dm_en", reg_en, 9'h0C0);
        chk("mv_dm_isel", i_sel, 1);
        cyc;
        chk("mv_i_src", source_sel, 7);
        chk("mv_i_en", reg_en, 9'h040);
        chk("mv_i_isel", i_sel, 0);
        // reset overrides decode combinationally
        sync_reset = 1'b1;
        #1;
        chk("rst_override_en", reg_en, 0);
        chk("rst_override_src", source_sel, 10);
        cyc;
        sync_reset = 1'b0;
        chk("rst_pc_clear", pm_address, 0);

        // ---- decode vector table ----
        for (int k = 0; k < 14; k++) begin
            clear_pm();
            pm[0] = vt[k].ins;
            pm[1] = 8'h20;
            do_reset();
            cyc;
            chk($sformatf("vec%0d_ir", k), ir, vt[k].ins);
            chk($sformatf("vec%0d_src", k), source_sel, vt[k].ss);
            chk($sformatf("vec%0d_en", k), reg_en, vt[k].re);
            chk($sformatf("vec%0d_isel", k), i_sel, vt[k].is);
            chk($sformatf("vec%0d_x", k), x_sel, vt[k].ins[4]);
            chk($sformatf("vec%0d_y", k), y_sel, vt[k].ins[3]);
            chk($sformatf("vec%0d_nib", k), ir_nibble, vt[k].ins[3:0]);
        end

        // ---- JMP with bubble ----
        clear_pm();
        pm[3] = 8'hE0; pm[4] = 8'h20; pm[8'h20] = 8'h05;
        do_reset();
        cyc; cyc; cyc;
        chk("jmp_pc3", pm_address, 3);
        cyc;
        chk("jmp_pc4", pm_address, 4);
        chk("jmp_run_en", reg_en, 0);
        cyc;
        chk("jmp_bub_pc", pm_address, 8'h20);
        chk("jmp_bub_en", reg_en, 0);
        chk("jmp_bub_src", source_sel, 10);
        cyc;
        chk("jmp_after_pc", pm_address, 8'h21);
        chk("jmp_after_ir", ir, 8'h05);
        chk("jmp_after_en", reg_en, 9'h001);

        // ---- reset during bubble of taken jump ----
        do_reset();
        cyc; cyc; cyc; cyc; cyc;
        sync_reset = 1'b1;
        #1;
        chk("rstbub_en", reg_en, 0);
        cyc;
        sync_reset = 1'b0;
        chk("rstbub_pc", pm_address, 0);
        cyc;
        chk("rstbub_restart_pc", pm_address, 1);
        chk("rstbub_restart_ir", ir, 8'h00);

        // ---- reset during RUN cycle of jump: reset wins ----
        do_reset();
        cyc; cyc; cyc; cyc;
        sync_reset = 1'b1;
        cyc;
        sync_reset = 1'b0;
        chk("rstrun_pc", pm_address, 0);

        // ---- JZ not taken / taken ----
        clear_pm();
        pm[3] = 8'hF8; pm[4] = 8'h40; pm[5] = 8'h05; pm[8'h40] = 8'hD2;
        r_eq_0 = 1'b0;
        do_reset();
        cyc; cyc; cyc; cyc;
        cyc;
        chk("jz_nt_pc", pm_address, 5);
        cyc;
        chk("jz_nt_pc6", pm_address, 6);
        chk("jz_nt_ir", ir, 8'h05);
        r_eq_0 = 1'b1;
        do_reset();
        cyc; cyc; cyc; cyc;
        cyc;
        chk("jz_t_pc", pm_address, 8'h40);
        cyc;
        chk("jz_t_ir", ir, 8'hD2);

        // ---- jump whose target byte sits at the last address ----
        clear_pm();
        pm[8'hFE] = 8'hF8; pm[8'hFF] = 8'h10;
        r_eq_0 = 1'b0;
        do_reset();
        for (int c = 0; c < 255; c++) cyc;
        chk("edge_pcFF", pm_address, 8'hFF);
        cyc;
        chk("edge_nt_wrap", pm_address, 0);
        r_eq_0 = 1'b1;
        do_reset();
        for (int c = 0; c < 255; c++) cyc;
        cyc;
        chk("edge_t_pc", pm_address, 8'h10);

        // ---- random program against reference model ----
        for (int i = 0; i < 256; i++) pm[i] = 8'($urandom);
        sync_reset = 1'b1;
        cyc;
        m_pc = 8'h00; m_ir = 8'h00; m_bub = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) begin
                for (int i = 0; i < 256; i++) pm[i] = 8'($urandom);
            end
            sync_reset = ($urandom_range(0, 39) == 0);
            r_eq_0     = 1'($urandom);
            #4;
            ref_dec(m_ir, m_bub, sync_reset, ess, ere, eis);
            chk("rnd_pc", pm_address, m_pc);
            chk("rnd_ir", ir, m_ir);
            chk("rnd_src", source_sel, ess);
            chk("rnd_en", reg_en, ere);
            chk("rnd_isel", i_sel, eis);
            chk("rnd_x", x_sel, m_ir[4]);
            chk("rnd_y", y_sel, m_ir[3]);
            chk("rnd_nib", ir_nibble, m_ir[3:0]);
            nxt = pm[m_pc];
            if (sync_reset) begin
                m_pc = 8'h00; m_ir = 8'h00; m_bub = 1'b1;
            end else if (!m_bub && m_ir >= 8'hE0) begin
                if (m_ir < 8'hF0)      taken = 1'b1;
                else if (m_ir < 8'hF8) taken = (r_eq_0 == 1'b0);
                else                   taken = (r_eq_0 == 1'b1);
                m_pc  = taken ? nxt : 8'(m_pc + 8'd1);
                m_ir  = nxt;
                m_bub = 1'b1;
            end else begin
                m_pc  = 8'(m_pc + 8'd1);
                m_ir  = nxt;
                m_bub = 1'b0;
            end
            cyc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
